// File: rtl/calc3_req_issuer.sv
// calc3_req_issuer: per-port CALC-3 request issue stage. Queues requester commands,
// issues one per cycle with the lowest free 2-bit tag, and matches tagged responses.
module calc3_req_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_TAGS   = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:3]  in_cmd,
  input  logic [0:3]  in_d1,
  input  logic [0:3]  in_d2,
  input  logic [0:3]  in_r1,
  input  logic [0:31] in_data,
  output logic [0:3]  req_cmd,
  output logic [0:3]  req_d1,
  output logic [0:3]  req_d2,
  output logic [0:3]  req_r1,
  output logic [0:31] req_data,
  output logic [0:1]  req_tag,
  input  logic [0:1]  out_resp,
  input  logic [0:1]  out_tag,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  output logic [0:1]  rsp_code,
  output logic [0:1]  rsp_tag,
  output logic [0:3]  rsp_cmd,
  output logic [0:31] rsp_data,
  output logic [0:3]  busy_tags,
  output logic        err_spurious
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]     TAG_LIMIT = 3'(NUM_TAGS);

  typedef struct packed {
    logic [0:3]  cmd;
    logic [0:3]  d1;
    logic [0:3]  d2;
    logic [0:3]  r1;
    logic [0:31] data;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [0:3]       busy;
  logic [0:3]       busy_next;
  logic [0:3]       tag_cmd [4];

  entry_t     in_entry;
  entry_t     src;
  logic       fifo_empty;
  logic       push;
  logic       src_valid;
  logic       src_noop;
  logic       issue;
  logic       issue_tagged;
  logic       write_fifo;
  logic       pop_fifo;
  logic       free_found;
  logic [0:1] free_tag;
  logic       rsp_any;
  logic       rsp_hit;
  logic       tag_in_range;

  // When the queue is empty an accepted command bypasses it and issues at the same edge.
  always_comb begin
    in_ready     = (count != DEPTH_CNT);
    push         = in_valid & in_ready;
    fifo_empty   = (count == '0);
    in_entry     = {in_cmd, in_d1, in_d2, in_r1, in_data};
    src          = fifo_empty ? in_entry : mem[rd_ptr];
    src_valid    = fifo_empty ? push : 1'b1;
    src_noop     = (src.cmd == 4'b0000);
    issue        = src_valid & (src_noop | free_found);
    issue_tagged = issue & ~src_noop;
    write_fifo   = push & ~(fifo_empty & issue);
    pop_fifo     = issue & ~fifo_empty;
  end

  // Lowest-numbered free tag, judged on the busy state before this edge.
  always_comb begin
    free_found = 1'b0;
    free_tag   = 2'b00;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_tag   = 2'(i);
      end
    end
  end

  always_comb begin
    rsp_any      = (out_resp != 2'b00);
    tag_in_range = ({1'b0, out_tag} < TAG_LIMIT);
    rsp_hit      = rsp_any & tag_in_range & busy[out_tag];
    busy_next    = busy;
    if (rsp_hit) begin
      busy_next[out_tag] = 1'b0;
    end
    if (issue_tagged) begin
      busy_next[free_tag] = 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (write_fifo) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      busy         <= '0;
      err_spurious <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tag_cmd[i] <= '0;
      end
    end else begin
      if (write_fifo) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fifo) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, write_fifo} - {{PTR_W{1'b0}}, pop_fifo};
      busy  <= busy_next;
      if (issue_tagged) begin
        tag_cmd[free_tag] <= src.cmd;
      end
      if (rsp_any & ~rsp_hit) begin
        err_spurious <= 1'b1;
      end
    end
  end

  // Request port is driven for exactly one cycle per issue, all-zero otherwise.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      req_cmd  <= '0;
      req_d1   <= '0;
      req_d2   <= '0;
      req_r1   <= '0;
      req_data <= '0;
      req_tag  <= '0;
    end else begin
      req_cmd  <= issue ? src.cmd  : '0;
      req_d1   <= issue ? src.d1   : '0;
      req_d2   <= issue ? src.d2   : '0;
      req_r1   <= issue ? src.r1   : '0;
      req_data <= issue ? src.data : '0;
      req_tag  <= issue_tagged ? free_tag : '0;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_code  <= '0;
      rsp_tag   <= '0;
      rsp_cmd   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_hit;
      rsp_code  <= rsp_hit ? out_resp : '0;
      rsp_tag   <= rsp_hit ? out_tag : '0;
      rsp_cmd   <= rsp_hit ? tag_cmd[out_tag] : '0;
      rsp_data  <= rsp_hit ? out_data : '0;
    end
  end

  assign busy_tags = busy;

endmodule

// File: doc/calc3_req_issuer.md
Name: calc3_req_issuer

Overview:
- Per-port request issue stage directly upstream of one CALC-3 request port (reqN_* / outN_* signal group).
- Queues commands from a requester and drives each one onto the port for exactly one cycle with a free 2-bit tag.
- Tracks outstanding tags and matches returning outN_resp/outN_tag responses to the original command, reporting completions back to the requester.
- Four instances cover ports 1-4.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
NUM_TAGS, 4, tags available; fixed by the 2-bit tag field, legal values 1..4

Ports:
c_clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous assert, active-low; low clears all state
in_valid  input  1  requester command valid
in_ready  output  1  queue can accept (count < FIFO_DEPTH)
in_cmd  input  [0:3]  CALC-3 opcode
in_d1  input  [0:3]  operand-1 register
in_d2  input  [0:3]  operand-2 register
in_r1  input  [0:3]  result register
in_data  input  [0:31]  store data
req_cmd  output  [0:3]  to calc reqN_cmd
req_d1  output  [0:3]  to reqN_d1
req_d2  output  [0:3]  to reqN_d2
req_r1  output  [0:3]  to reqN_r1
req_data  output  [0:31]  to reqN_data
req_tag  output  [0:1]  to reqN_tag
out_resp  input  [0:1]  from calc outN_resp
out_tag  input  [0:1]  from calc outN_tag
out_data  input  [0:31]  from calc outN_data
rsp_valid  output  1  one-cycle completion pulse
rsp_code  output  [0:1]  captured out_resp
rsp_tag  output  [0:1]  completed tag
rsp_cmd  output  [0:3]  opcode originally issued on that tag
rsp_data  output  [0:31]  captured out_data
busy_tags  output  [0:3]  bit i = tag i outstanding
err_spurious  output  1  sticky: response on a non-outstanding tag

Behaviour:
- Reset values (reset low, asynchronous):
  - FIFO empty; all tags free.
  - All req_* outputs 0, so req_cmd = 0000 (no-op).
  - rsp_valid = 0, rsp_* = 0, busy_tags = 0, err_spurious = 0.
- Enqueue:
  - in_valid & in_ready at an edge writes {cmd,d1,d2,r1,data}.
  - in_ready is combinational from count only. A pop in the same cycle does not raise it.
  - in_cmd = 0000 is still enqueued and issued. A no-op occupies no tag and produces no response.
- Issue:
  - At each edge, if the FIFO is non-empty and a tag in 0..NUM_TAGS-1 is free (by the pre-edge busy state), pop the head entry.
  - Register the entry onto req_* with req_tag = lowest-numbered free tag.
  - Set that busy bit and record cmd in the tag table.
  - Exception: a no-op pops without needing a free tag, and sets no busy bit.
- Issue latency and cycle rules:
  - Command accepted at edge N is driven on req_* during cycle N+1, provided the FIFO was empty and a tag was free.
  - req_* is held for exactly one cycle. The following cycle it returns to all-zero unless another entry issues back-to-back.
  - At most one issue per cycle. Issue is strictly FIFO order: no bypass while the head waits for a tag.
- Response:
  - out_resp != 00 sampled at edge M with busy[out_tag] = 1:
    - clears busy[out_tag];
    - drives rsp_valid = 1 during cycle M+1 with rsp_code/rsp_tag/rsp_data captured and rsp_cmd from the tag table.
  - rsp_valid is low in every other cycle.
  - out_resp = 00 means no response.
- Spurious response: out_resp != 00 with busy[out_tag] = 0, or out_tag >= NUM_TAGS, sets err_spurious.
  - No rsp_valid; busy state unchanged.
  - err_spurious clears only on reset.
- Tag reuse: a tag freed at edge M is not seen by the issue decision at edge M. It is first reusable at edge M+1, so the earliest reissued request appears in cycle M+2.
- Same-edge events:
  - Issue and response on different tags at the same edge: both take effect.
  - Enqueue and issue at the same edge: count unchanged.
- Full/empty:
  - count saturates at FIFO_DEPTH with in_ready = 0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - No issue when empty.
- Reset mid-operation flushes the queue and frees all tags. Any later response for a pre-reset tag is flagged spurious.

Test Plan:
- Single add: in_cmd=0001, d1=3, d2=4, r1=5 at edge 0 -> cycle 1 shows req_cmd=0001, req_tag=00; cycle 2 shows req_cmd=0000. Then out_resp=01, out_tag=00 at edge 10 -> rsp_valid in cycle 11 with rsp_cmd=0001, busy_tags=0000.
- Tag exhaustion: enqueue 5 adds with no responses -> tags 00,01,10,11 issue in cycles 1-4; the 5th is held and busy_tags=1111. Respond to tag 10 at edge M -> 5th issues with req_tag=10 in cycle M+2.
- FIFO full: 4 tags busy, then enqueue 4 more -> in_ready=0 after the 4th. A 5th in_valid is not accepted and count stays 4.
- Out-of-order completion: issue tags 0-2, respond 2,0,1 -> rsp_tag sequence 10,00,01 with matching rsp_cmd and rsp_data values.
- Spurious: out_resp=01, out_tag=11 with no tag outstanding -> err_spurious=1 and stays 1, no rsp_valid. Also: assert reset low for 1 cycle with 2 tags busy -> busy_tags=0000, req_cmd=0000, err_spurious=0 immediately (asynchronously).
- No-op: enqueue 0000 between two adds -> three back-to-back issue cycles; the no-op uses no tag, so the second add gets tag 01.
